spi_flash_cmd: RTL
==================

Name: spi_flash_cmd

Overview:
- Command decoder and responder that sits directly downstream of the SPI device byte interface, in the same clk domain.
- Consumes received bytes (spi_rx_cmd/spi_rx_strobe/spi_rx_data) and parses SPI-flash opcodes and 24-bit addresses.
- Fetches bytes from a single-outstanding memory read port and returns response bytes (spi_tx_data/spi_tx_strobe/spi_tx_strobe_immediate) back to the SPI device.
- Supported opcodes: READ 0x03, FAST_READ 0x0B, RDSR 0x05, RDID 0x9F. All others are ignored.

Parameters:
- ADDR_WIDTH, 24: memory address width. Incoming 24-bit addresses are truncated to their low ADDR_WIDTH bits.
- JEDEC_ID, 24'hEF4018: RDID response, sent MSB byte first.
- STATUS, 8'h00: RDSR response byte.
- LATE_CYCLES, 4: threshold, in clk cycles after the triggering strobe, beyond which data is loaded with the immediate strobe.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_rx_cmd  in  1  first byte of a transaction (qualifies spi_rx_strobe)
- spi_rx_strobe  in  1  one-cycle pulse: spi_rx_data valid
- spi_rx_data  in  8  received byte
- spi_tx_data  out  8  response byte
- spi_tx_strobe  out  1  one-cycle pulse: load spi_tx_data for the next byte
- spi_tx_strobe_immediate  out  1  one-cycle pulse: load spi_tx_data and the current output bit
- mem_addr  out  ADDR_WIDTH  read address; held stable from mem_rd until mem_valid
- mem_rd  out  1  one-cycle read request
- mem_data  in  8  read data
- mem_valid  in  1  one-cycle pulse: mem_data valid
- cmd_active  out  1  high while a supported command is being serviced
- underrun  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - state IDLE; all strobes, mem_rd, cmd_active and underrun = 0.
  - spi_tx_data = 8'hFF, mem_addr = 0, internal address = 0, late counter = 0.
- Strobe outputs: spi_tx_strobe, spi_tx_strobe_immediate and mem_rd are registered one-cycle pulses, never asserted together.
- States: IDLE, ADDR2, ADDR1, ADDR0, DUMMY, WAIT, STREAM, ID, STAT, IGNORE.
- New command (spi_rx_strobe && spi_rx_cmd), from any state:
  - Abandon the current command. A still-outstanding read is marked discard, and its mem_valid is dropped without any tx strobe.
  - Decode spi_rx_data:
    - 0x03 or 0x0B -> ADDR2; latch opcode.
    - 0x9F -> ID; next cycle spi_tx_data = JEDEC_ID[23:16] with spi_tx_strobe.
    - 0x05 -> STAT; next cycle spi_tx_data = STATUS with spi_tx_strobe.
    - other -> IGNORE; no tx strobes (device shifts out 1s).
- Address phase, on spi_rx_strobe:
  - ADDR2 latches addr[23:16] -> ADDR1; ADDR1 latches addr[15:8] -> ADDR0.
  - ADDR0 latches addr[7:0], then: opcode 0x03 -> WAIT, issuing mem_rd; opcode 0x0B -> DUMMY.
  - DUMMY: on spi_rx_strobe -> WAIT, issuing mem_rd.
- mem_rd issue:
  - Asserted the cycle after the triggering strobe, with mem_addr = internal address.
  - If a discarded request is still outstanding, mem_rd waits until its mem_valid has been consumed. The late counter keeps running meanwhile.
- Late counter: resets to 0 on the triggering strobe and increments each cycle until mem_valid.
- WAIT, on non-discarded mem_valid:
  - Next cycle spi_tx_data = mem_data.
  - Pulse spi_tx_strobe if late counter <= LATE_CYCLES, else spi_tx_strobe_immediate.
  - Internal address += 1, wrapping modulo 2^ADDR_WIDTH.
  - -> STREAM.
- STREAM, on spi_rx_strobe: issue mem_rd for the next address -> WAIT.
- Strobe during WAIT: a non-cmd spi_rx_strobe sets underrun and is otherwise dropped (no extra fetch, address not advanced).
- ID, on each spi_rx_strobe: load JEDEC_ID[15:8], then [7:0], then 8'hFF for every later byte, each with spi_tx_strobe.
- STAT, on each spi_rx_strobe: reload STATUS with spi_tx_strobe (continuous status polling).
- IGNORE: all non-cmd strobes ignored.
- cmd_active: 1 in every state except IDLE and IGNORE.
- Simultaneous mem_valid and new command: the new command wins; the data is discarded.
- Reset mid-operation:
  - Everything returns to reset values, including dropping discard and pending-request tracking.
  - A mem_valid arriving after reset is ignored.

Test Plan:
- READ: cmd 0x03, bytes 0x00 0x12 0x34; mem returns 0xA5 two cycles after mem_rd -> mem_addr 0x001234, one spi_tx_strobe with 0xA5. Next strobe -> mem_rd at 0x001235.
- FAST_READ: cmd 0x0B, address 0x00 0x00 0x10, dummy 0x00 -> no mem_rd before the dummy strobe; mem_rd at 0x000010 afterwards.
- RDID: cmd 0x9F plus 4 strobes -> tx sequence 0xEF, 0x40, 0x18, 0xFF, 0xFF, each via spi_tx_strobe. RDSR: cmd 0x05 plus 3 strobes -> 0x00 four times.
- Late data: mem_valid 6 cycles after the triggering strobe (LATE_CYCLES=4) -> spi_tx_strobe_immediate only, no spi_tx_strobe.
- Wrap and underrun: READ at 0xFFFFFF -> the next fetch is at 0x000000. A strobe while WAIT is outstanding -> underrun = 1 and stays 1 until reset.
- Abort: new cmd 0x05 while a read is outstanding; the old mem_valid arrives 3 cycles later -> no tx strobe for it, STATUS loaded. Reset asserted in STREAM -> IDLE, spi_tx_data 0xFF, cmd_active 0.

Source files
------------

// File: rtl/spi_flash_cmd_if.sv
// spi_flash_cmd_if: byte-level SPI device and memory read-port signals around the flash command decoder
interface spi_flash_cmd_if #(parameter int ADDR_WIDTH = 24);
  logic spi_rx_cmd;
  logic spi_rx_strobe;
  logic [7:0] spi_rx_data;
  logic [7:0] spi_tx_data;
  logic spi_tx_strobe;
  logic spi_tx_strobe_immediate;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_data;
  logic mem_valid;
  logic cmd_active;
  logic underrun;
  modport master (
    output spi_rx_cmd, spi_rx_strobe, spi_rx_data, mem_data, mem_valid,
    input spi_tx_data, spi_tx_strobe, spi_tx_strobe_immediate, mem_addr, mem_rd, cmd_active, underrun
  );
  modport slave (
    input spi_rx_cmd, spi_rx_strobe, spi_rx_data, mem_data, mem_valid,
    output spi_tx_data, spi_tx_strobe, spi_tx_strobe_immediate, mem_addr, mem_rd, cmd_active, underrun
  );
endinterface

// File: rtl/spi_flash_cmd.sv
// spi_flash_cmd: parses SPI-flash READ/FAST_READ/RDSR/RDID opcodes and streams response bytes from a single-outstanding memory port
module spi_flash_cmd #(
  parameter int ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter logic [7:0] STATUS = 8'h00,
  parameter int LATE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  spi_flash_cmd_if.slave bus
);
  localparam int LW = $clog2(LATE_CYCLES + 2);
  localparam logic [LW-1:0] LATE_MAX = LW'(LATE_CYCLES);
  typedef enum logic [3:0] {IDLE, ADDR2, ADDR1, ADDR0, DUMMY, WAIT, STREAM, ID, STAT, IGNORE} state_t;
  state_t state, dec;
  logic fast, busy, discard, rd_req, nc, db, consume, trig;
  logic [1:0] id_idx;
  logic [LW-1:0] late_cnt;
  logic [ADDR_WIDTH-1:0] addr, shift_addr, trig_addr;
  always_comb begin
    nc = bus.spi_rx_strobe && bus.spi_rx_cmd;
    db = bus.spi_rx_strobe && !bus.spi_rx_cmd;
    consume = bus.mem_valid && busy;
    dec = (bus.spi_rx_data == 8'h03 || bus.spi_rx_data == 8'h0B) ? ADDR2 :
          bus.spi_rx_data == 8'h9F ? ID : bus.spi_rx_data == 8'h05 ? STAT : IGNORE;
    shift_addr = ADDR_WIDTH'({addr, bus.spi_rx_data});
    trig = db && ((state == ADDR0 && !fast) || state == DUMMY || state == STREAM);
    trig_addr = state == ADDR0 ? shift_addr : addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fast <= 1'b0;
      busy <= 1'b0;
      discard <= 1'b0;
      rd_req <= 1'b0;
      id_idx <= '0;
      late_cnt <= '0;
      addr <= '0;
      bus.spi_tx_data <= 8'hFF;
      bus.spi_tx_strobe <= 1'b0;
      bus.spi_tx_strobe_immediate <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_rd <= 1'b0;
      bus.cmd_active <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.spi_tx_strobe <= 1'b0;
      bus.spi_tx_strobe_immediate <= 1'b0;
      bus.mem_rd <= 1'b0;
      if (late_cnt <= LATE_MAX) late_cnt <= late_cnt + 1'b1;
      if (consume) begin
        busy <= 1'b0;
        discard <= 1'b0;
      end
      if (nc) begin
        state <= dec;
        fast <= bus.spi_rx_data == 8'h0B;
        id_idx <= '0;
        rd_req <= 1'b0;
        discard <= busy && !bus.mem_valid;
        bus.cmd_active <= dec != IGNORE;
        if (dec == ID || dec == STAT) begin
          bus.spi_tx_data <= dec == ID ? JEDEC_ID[23:16] : STATUS;
          bus.spi_tx_strobe <= 1'b1;
        end
      end else begin
        // a fetch held back behind a discarded read goes out once that read returns
        if (rd_req && consume && discard) begin
          bus.mem_rd <= 1'b1;
          bus.mem_addr <= addr;
          busy <= 1'b1;
          rd_req <= 1'b0;
        end
        if (trig) begin
          late_cnt <= '0;
          if (!busy || bus.mem_valid) begin
            bus.mem_rd <= 1'b1;
            bus.mem_addr <= trig_addr;
            busy <= 1'b1;
          end else rd_req <= 1'b1;
        end
        case (state)
          ADDR2: if (db) begin
            addr <= shift_addr;
            state <= ADDR1;
          end
          ADDR1: if (db) begin
            addr <= shift_addr;
            state <= ADDR0;
          end
          ADDR0: if (db) begin
            addr <= shift_addr;
            state <= fast ? DUMMY : WAIT;
          end
          DUMMY, STREAM: if (db) state <= WAIT;
          WAIT: begin
            if (db) bus.underrun <= 1'b1;
            if (consume && !discard) begin
              bus.spi_tx_data <= bus.mem_data;
              bus.spi_tx_strobe <= late_cnt <= LATE_MAX;
              bus.spi_tx_strobe_immediate <= late_cnt > LATE_MAX;
              addr <= addr + 1'b1;
              state <= STREAM;
            end
          end
          ID: if (db) begin
            bus.spi_tx_data <= id_idx == 2'd0 ? JEDEC_ID[15:8] : id_idx == 2'd1 ? JEDEC_ID[7:0] : 8'hFF;
            bus.spi_tx_strobe <= 1'b1;
            id_idx <= id_idx == 2'd2 ? id_idx : id_idx + 1'b1;
          end
          STAT: if (db) begin
            bus.spi_tx_data <= STATUS;
            bus.spi_tx_strobe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
